linear_layer_bwd: RTL and testbench
===================================

# linear_layer_bwd

Sequential backward (transpose) pass of one fully-connected linear layer: takes an output-gradient vector `grad_out` (NOUT entries) and computes `grad_in = W^T * grad_out` (NIN entries) with one shared multiply-accumulate unit. It sits behind each combinational `linearLayer` stage in the network and propagates error vectors from the network output back towards its input. It uses the same flat weight parameter as the forward layer, so one weight constant drives both directions. Input and output use valid/ready handshakes.

## Interface
- `WIDTH`, 16: signed data and weight width.
- `NIN`, 4: forward-layer input count; this block's output vector length.
- `NOUT`, 3: forward-layer output count; this block's input vector length.
- `FRAC`, 0: arithmetic right shift applied to each accumulated sum before saturation.
- `WEIGHTS_MATRIX_FLAT`, 0: `WIDTH*NIN*NOUT` bits, signed, row-major (row i = forward output i).
  - Element W[i][j] sits at bits `[(NIN*NOUT-(i*NIN+j))*WIDTH-1 -: WIDTH]`, so W[0][0] occupies the MSBs.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `in_valid  in  1`: `grad_out` is valid.
- `in_ready  out  1`: block can accept a vector.
- `grad_out  in  signed [WIDTH-1:0] [0:NOUT-1]`: output-gradient vector.
- `out_valid  out  1`: `grad_in` is valid.
- `out_ready  in  1`: downstream accepts `grad_in`.
- `grad_in  out  signed [WIDTH-1:0] [0:NIN-1]`: input-gradient vector, registered.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - COMPUTE.
  - DONE: `out_valid`=1.
- IDLE -> COMPUTE on `in_valid && in_ready`:
  - capture `grad_out` into an internal register;
  - set i=0, j=0, acc=0.
  - `grad_out` may change freely after capture.
- COMPUTE performs one MAC per cycle: `acc_next = acc + W[i][j]*g[i]`.
  - Product width is 2*WIDTH.
  - Accumulator width is 2*WIDTH + clog2(NOUT) + 1; it never overflows internally.
  - Inner index i runs 0..NOUT-1. Outer index j runs 0..NIN-1.
  - When i==NOUT-1:
    - write `sat(acc_next >>> FRAC)` into result buffer entry j;
    - clear acc, set i=0, increment j.
  - When i==NOUT-1 and j==NIN-1: copy the full result buffer into `grad_in` and go to DONE.
- Saturation clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. The shift is arithmetic (sign-preserving), truncating toward negative infinity.
- `grad_in` changes only on the COMPUTE->DONE transition (and on reset). Partial results are never visible.
- DONE -> IDLE on `out_ready`. While in DONE, `grad_in` and `out_valid` stay stable.
- `in_ready` is 0 in COMPUTE and DONE. `in_valid` in those states is ignored and no vector is captured.
- Reset (asynchronous, any state, including mid-COMPUTE):
  - state=IDLE, `out_valid`=0, all `grad_in`=0, acc=0, indices=0;
  - the in-flight vector is discarded;
  - `in_ready` is held 0 while `rst` is high.

## Timing
- Accept edge E0 (handshake in IDLE). COMPUTE occupies NIN*NOUT cycles. `out_valid` rises after edge E0+NIN*NOUT (12 cycles at defaults).
- `out_valid` falls on the first edge where `out_ready`=1. `in_ready` rises in the same cycle.
- Minimum initiation interval: NIN*NOUT+2 cycles (accept, compute, one DONE cycle, back to IDLE).
- No combinational path from `in_valid` or `out_ready` to any output other than the FSM next state. `in_ready` and `out_valid` are decoded from state (and `rst`).
- `out_ready` asserted before DONE has no effect.
- After reset release, the first accept is possible on the first rising edge.

## Test plan
- Unit vector: W rows {30,780,-25,-77},{308,-78,-250,-779},{-302,788,-250,-77}, FRAC=0, `grad_out`={1,0,0}, `out_ready`=1 -> `grad_in`={30,780,-25,-77}. `out_valid` rises exactly 12 cycles after the accept edge and stays high 1 cycle.
- All ones: same W, `grad_out`={1,1,1} -> `grad_in`={36,1490,-525,-933}.
- Saturation: `grad_out`={100,100,100} -> `grad_in`={3600,32767,-32768,-32768}. With FRAC=4 and `grad_out`={1,1,1} -> {2,93,-33,-59}.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` rises, and toggle `in_valid` with a new vector -> `grad_in` stable, `in_ready`=0, new vector not captured. Release -> IDLE next cycle, then the new vector processes correctly.
- Reset mid-compute: assert `rst` during the 5th COMPUTE cycle -> immediately `out_valid`=0, `grad_in`=0. After release, send {1,0,0} -> {30,780,-25,-77} with full 12-cycle latency.
- Back-to-back: `in_valid` held high with vectors {1,0,0} then {1,1,1}, `out_ready`=1 -> two outputs in order, 14 cycles apart, no lost or duplicated vector.

Source files
------------

// File: rtl/linear_layer_bwd.sv
// Transpose (backward) pass of a fully-connected layer: grad_in = W^T * grad_out.
// One shared multiply-accumulate unit is stepped across the weight matrix, one
// product per cycle. Handshakes are valid/ready on both sides.
module linear_layer_bwd #(
  parameter int WIDTH = 16,
  parameter int NIN   = 4,
  parameter int NOUT  = 3,
  parameter int FRAC  = 0,
  parameter logic [WIDTH*NIN*NOUT-1:0] WEIGHTS_MATRIX_FLAT = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] grad_out [0:NOUT-1],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] grad_in  [0:NIN-1]
);

  // Wide enough to sum NOUT full products with a guard bit, so it cannot wrap.
  localparam int ACC_W = 2*WIDTH + $clog2(NOUT) + 1;
  localparam int IW    = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam int JW    = (NIN  > 1) ? $clog2(NIN)  : 1;
  localparam logic [IW-1:0] I_LAST = IW'(NOUT-1);
  localparam logic [JW-1:0] J_LAST = JW'(NIN-1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t                    state, state_nxt;
  logic                      accept;
  logic [IW-1:0]             i_idx;
  logic [JW-1:0]             j_idx;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [WIDTH-1:0]   g_p0 [0:NOUT-1];
  logic signed [WIDTH-1:0]   res  [0:NIN-1];
  logic signed [WIDTH-1:0]   wmat [0:NOUT-1][0:NIN-1];
  logic signed [WIDTH-1:0]   w_cur;
  logic signed [WIDTH-1:0]   g_cur;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [WIDTH-1:0]   sat_val;
  logic                      col_end;
  logic                      last_mac;

  // Arithmetic right shift (floor) followed by clamping to the WIDTH range.
  function automatic logic signed [WIDTH-1:0] shift_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> FRAC;
    if (s > SAT_MAX)      return SAT_MAX[WIDTH-1:0];
    else if (s < SAT_MIN) return SAT_MIN[WIDTH-1:0];
    else                  return s[WIDTH-1:0];
  endfunction

  // Unflatten the weight constant; W[0][0] lives in the MSBs.
  for (genvar gi = 0; gi < NOUT; gi++) begin : g_row
    for (genvar gj = 0; gj < NIN; gj++) begin : g_col
      assign wmat[gi][gj] = WEIGHTS_MATRIX_FLAT[(NIN*NOUT-(gi*NIN+gj))*WIDTH-1 -: WIDTH];
    end
  end

  // MAC datapath: current weight times captured gradient, added to the running sum.
  always_comb begin
    w_cur    = wmat[i_idx][j_idx];
    g_cur    = g_p0[i_idx];
    prod     = w_cur * g_cur;
    acc_sum  = acc + $signed({{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod});
    sat_val  = shift_sat(acc_sum);
    col_end  = (i_idx == I_LAST);
    last_mac = col_end && (j_idx == J_LAST);
  end

  // Next-state and handshake decode; outputs depend on state and rst only.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept    = 1'b1;
          state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        if (last_mac) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state, indices, accumulator and the visible result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      i_idx <= '0;
      j_idx <= '0;
      acc   <= '0;
      for (int k = 0; k < NIN; k++) grad_in[k] <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        i_idx <= '0;
        j_idx <= '0;
        acc   <= '0;
      end else if (state == COMPUTE) begin
        if (col_end) begin
          acc   <= '0;
          i_idx <= '0;
          j_idx <= last_mac ? '0 : j_idx + 1'b1;
        end else begin
          acc   <= acc_sum;
          i_idx <= i_idx + 1'b1;
        end
        // The final column is still in flight, so take it straight from sat_val.
        if (last_mac) begin
          for (int k = 0; k < NIN; k++)
            grad_in[k] <= (JW'(k) == j_idx) ? sat_val : res[k];
        end
      end
    end
  end

  // Captured input vector and column buffer: plain data, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < NOUT; k++) g_p0[k] <= grad_out[k];
    end
    if ((state == COMPUTE) && col_end) begin
      res[j_idx] <= sat_val;
    end
  end

endmodule

// File: tb/tb_linear_layer_bwd.sv
// Scoreboarded bench for linear_layer_bwd: two instances (FRAC=0 and FRAC=4)
// share stimulus; a monitor pops hand-computed expectations on each output.
module tb_linear_layer_bwd;

  localparam int WIDTH = 16;
  localparam int NIN   = 4;
  localparam int NOUT  = 3;
  localparam logic [WIDTH*NIN*NOUT-1:0] WFLAT = {
    16'sd30,   16'sd780, -16'sd25,  -16'sd77,
    16'sd308, -16'sd78,  -16'sd250, -16'sd779,
    -16'sd302, 16'sd788, -16'sd250, -16'sd77};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic signed [WIDTH-1:0] grad_out [0:NOUT-1];
  logic in_ready0, out_valid0, in_ready4, out_valid4;
  logic signed [WIDTH-1:0] gi0 [0:NIN-1];
  logic signed [WIDTH-1:0] gi4 [0:NIN-1];
  logic [63:0] gi0_pk, gi4_pk;

  assign gi0_pk = {gi0[0], gi0[1], gi0[2], gi0[3]};
  assign gi4_pk = {gi4[0], gi4[1], gi4[2], gi4[3]};

  linear_layer_bwd #(.WIDTH(WIDTH), .NIN(NIN), .NOUT(NOUT), .FRAC(0),
                     .WEIGHTS_MATRIX_FLAT(WFLAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .grad_out(grad_out), .out_valid(out_valid0), .out_ready(out_ready),
    .grad_in(gi0));

  linear_layer_bwd #(.WIDTH(WIDTH), .NIN(NIN), .NOUT(NOUT), .FRAC(4),
                     .WEIGHTS_MATRIX_FLAT(WFLAT)) dut_f4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .grad_out(grad_out), .out_valid(out_valid4), .out_ready(out_ready),
    .grad_in(gi4));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp0_q[$];
  logic [63:0] exp4_q[$];
  int          lat_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [63:0] mk(input int a, input int b, input int c, input int d);
    return {16'(a), 16'(b), 16'(c), 16'(d)};
  endfunction

  task automatic drive(input int a, input int b, input int c);
    grad_out[0] = 16'(a);
    grad_out[1] = 16'(b);
    grad_out[2] = 16'(c);
  endtask

  // Offer a vector until accepted; push its expectations and accept-edge number.
  task automatic send(input int a, input int b, input int c,
                      input logic [63:0] e0, input logic [63:0] e4,
                      input bit hold, output int acc_edge);
    int n;
    drive(a, b, c);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready0) begin
      fail("accept_timeout");
      in_valid = 1'b0;
      acc_edge = -1;
      return;
    end
    exp0_q.push_back(e0);
    exp4_q.push_back(e4);
    acc_edge = cyc + 1;
    lat_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp0_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp0_q.size() != 0) fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  // Monitor: latency on each rising out_valid, data on each handshake.
  initial begin
    bit ov_prev;
    bit hs_prev;
    int r;
    ov_prev = 1'b0;
    hs_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ov_prev = 1'b0;
        hs_prev = 1'b0;
      end else begin
        if (hs_prev) chk("out_valid_one_cycle", {63'd0, out_valid0}, 64'd0);
        if (out_valid0 && !ov_prev) begin
          if (lat_q.size() == 0) fail("unexpected_output");
          else begin
            r = lat_q.pop_front();
            chk("latency", 64'(cyc - r), 64'd12);
          end
        end
        if (out_valid0 && out_ready) begin
          if (exp0_q.size() == 0) fail("no_expected_entry");
          else begin
            chk("grad_in_frac0", gi0_pk, exp0_q.pop_front());
            chk("out_valid_frac4", {63'd0, out_valid4}, 64'd1);
            chk("grad_in_frac4", gi4_pk, exp4_q.pop_front());
          end
        end
        hs_prev = out_valid0 && out_ready;
        ov_prev = out_valid0;
      end
    end
  end

  initial begin
    int e1, e2;
    drive(0, 0, 0);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", {63'd0, in_ready0}, 64'd0);
    chk("reset_out_valid", {63'd0, out_valid0}, 64'd0);
    chk("reset_grad_in", gi0_pk, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", {63'd0, in_ready0}, 64'd1);

    // Directed vectors (expected: FRAC=0, FRAC=4)
    send(1, 0, 0, mk(30, 780, -25, -77), mk(1, 48, -2, -5), 1'b0, e1);
    drain();
    send(1, 1, 1, mk(36, 1490, -525, -933), mk(2, 93, -33, -59), 1'b0, e1);
    drain();
    send(100, 100, 100, mk(3600, 32767, -32768, -32768),
         mk(225, 9312, -3282, -5832), 1'b0, e1);
    drain();
    send(-100, -100, -100, mk(-3600, -32768, 32767, 32767),
         mk(-225, -9313, 3281, 5831), 1'b0, e1);
    drain();
    send(0, 0, -1, mk(302, -788, 250, 77), mk(18, -50, 15, 4), 1'b0, e1);
    drain();

    // Backpressure: hold out_ready low while toggling in_valid with another vector
    out_ready = 1'b0;
    send(2, -3, 5, mk(-2374, 5734, -550, 1798), mk(-149, 358, -35, 112), 1'b0, e1);
    begin
      int n;
      n = 0;
      while (!out_valid0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!out_valid0) fail("bp_wait_out_valid");
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      in_valid = k[0];
      drive(7, 7, 7);
      @(negedge clk);
      chk("bp_grad_in_stable", gi0_pk, mk(-2374, 5734, -550, 1798));
      chk("bp_in_ready_low", {63'd0, in_ready0}, 64'd0);
      chk("bp_out_valid_high", {63'd0, out_valid0}, 64'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_after_release", {63'd0, in_ready0}, 64'd1);
    @(posedge clk);
    #1;
    send(0, 1, 0, mk(308, -78, -250, -779), mk(19, -5, -16, -49), 1'b0, e1);
    drain();

    // Reset during the 5th COMPUTE cycle
    send(1, 1, 1, mk(36, 1490, -525, -933), mk(2, 93, -33, -59), 1'b0, e1);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midreset_out_valid", {63'd0, out_valid0}, 64'd0);
    chk("midreset_grad_in", gi0_pk, 64'd0);
    chk("midreset_grad_in_f4", gi4_pk, 64'd0);
    chk("midreset_in_ready", {63'd0, in_ready0}, 64'd0);
    exp0_q.delete();
    exp4_q.delete();
    lat_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(1, 0, 0, mk(30, 780, -25, -77), mk(1, 48, -2, -5), 1'b0, e1);
    drain();

    // Back-to-back with in_valid held high
    send(1, 0, 0, mk(30, 780, -25, -77), mk(1, 48, -2, -5), 1'b1, e1);
    send(1, 1, 1, mk(36, 1490, -525, -933), mk(2, 93, -33, -59), 1'b0, e2);
    chk("b2b_spacing", 64'(e2 - e1), 64'd14);
    drain();
    repeat (3) @(posedge clk);
    chk("leftover_expected", 64'(exp0_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
